// File: rtl/phy_pkg.sv
// Shared definitions for the PHY transmit path: word width, COMMA word, FSM encoding.
package phy_pkg;

    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] COMMA_WORD = 8'hBC;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } tx_state_e;

endpackage

// File: rtl/phy_tx_lane.sv
// One serializer lane: single-entry hold register feeding an MSB-first shift register.
module phy_tx_lane
    import phy_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA = COMMA_WORD
) (
    input  logic              clk_8f,
    input  logic              reset,
    input  logic              load,
    input  logic              active,
    input  logic [WORD_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready,
    output logic              data_out
);

    logic [WORD_W-1:0] hold_q;
    logic              hold_v_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] next_word;
    logic              accept;

    // Handshake: a byte transfers on the posedge where valid_in & ready are both high;
    // ready depends only on registered state, and valid_in while ready is low is ignored.
    assign ready     = active & ~hold_v_q;
    assign accept    = valid_in & ready;
    assign next_word = (active && hold_v_q) ? hold_q : COMMA;
    assign data_out  = shift_q[WORD_W-1];

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            shift_q  <= '0;
        end else begin
            if (load) begin
                shift_q <= next_word;
            end else begin
                shift_q <= {shift_q[WORD_W-2:0], 1'b0};
            end
            // Accept only happens with hold empty, so it never races a pending byte.
            if (accept) begin
                hold_q   <= data_in;
                hold_v_q <= 1'b1;
            end else if (load) begin
                hold_v_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/phy_tx_serializer.sv
// Two-lane PHY transmit serializer: COMMA sync burst after reset, then data or COMMA idle fill.
// Optional idle-word status counter enabled by defining PHY_TX_STATUS_EN.
module phy_tx_serializer
    import phy_pkg::*;
#(
    parameter int                SYNC_WORDS = 4,
    parameter logic [WORD_W-1:0] COMMA      = COMMA_WORD
) (
    input  logic              clk_8f,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in_c_0,
    input  logic              valid_in_c_0,
    output logic              ready_out_c_0,
    input  logic [WORD_W-1:0] data_in_c_1,
    input  logic              valid_in_c_1,
    output logic              ready_out_c_1,
    output logic              data_out_c_0,
    output logic              data_out_c_1,
    output logic              active_out
`ifdef PHY_TX_STATUS_EN
    ,
    output logic [7:0]        idle_cnt_out
`endif
);

    localparam int SYNC_W = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS - 1);

    logic [2:0]        bit_cnt_q;
    logic [SYNC_W-1:0] sync_cnt_q;
    tx_state_e         state_q;
    tx_state_e         state_d;
    logic              load;
    logic              active;

    assign load = (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= 3'd0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            sync_cnt_q <= '0;
        end else if (state_q == ST_SYNC && load) begin
            sync_cnt_q <= sync_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // ACTIVE is terminal; only reset returns the link to SYNC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC:   if (load && sync_cnt_q == SYNC_LAST) state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        active = (state_q == ST_ACTIVE);
    end

    assign active_out = active;

    phy_tx_lane #(.COMMA(COMMA)) u_lane_0 (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .load     (load),
        .active   (active),
        .data_in  (data_in_c_0),
        .valid_in (valid_in_c_0),
        .ready    (ready_out_c_0),
        .data_out (data_out_c_0)
    );

    phy_tx_lane #(.COMMA(COMMA)) u_lane_1 (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .load     (load),
        .active   (active),
        .data_in  (data_in_c_1),
        .valid_in (valid_in_c_1),
        .ready    (ready_out_c_1),
        .data_out (data_out_c_1)
    );

`ifdef PHY_TX_STATUS_EN
    logic [7:0] idle_cnt_q;

    // Lane 0 ready at a load edge means ACTIVE with hold empty: an idle COMMA goes out.
    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= 8'd0;
        end else if (load && ready_out_c_0 && idle_cnt_q != 8'hFF) begin
            idle_cnt_q <= idle_cnt_q + 8'd1;
        end
    end

    assign idle_cnt_out = idle_cnt_q;
`endif

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Bench for phy_tx_serializer: directed steps, queue scoreboard of expected serial words per lane.
module tb_phy_tx_serializer;
  import phy_pkg::*;

  localparam int SYNC_WORDS = 4;

  logic       clk_8f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in_c_0 = 8'h00;
  logic       valid_in_c_0 = 1'b0;
  logic       ready_out_c_0;
  logic [7:0] data_in_c_1 = 8'h00;
  logic       valid_in_c_1 = 1'b0;
  logic       ready_out_c_1;
  logic       data_out_c_0;
  logic       data_out_c_1;
  logic       active_out;
`ifdef PHY_TX_STATUS_EN
  logic [7:0] idle_cnt_out;
`endif

  always #5 clk_8f = ~clk_8f;

  phy_tx_serializer #(.SYNC_WORDS(SYNC_WORDS)) dut (
    .clk_8f        (clk_8f),
    .reset         (reset),
    .data_in_c_0   (data_in_c_0),
    .valid_in_c_0  (valid_in_c_0),
    .ready_out_c_0 (ready_out_c_0),
    .data_in_c_1   (data_in_c_1),
    .valid_in_c_1  (valid_in_c_1),
    .ready_out_c_1 (ready_out_c_1),
    .data_out_c_0  (data_out_c_0),
    .data_out_c_1  (data_out_c_1),
    .active_out    (active_out)
`ifdef PHY_TX_STATUS_EN
    ,
    .idle_cnt_out  (idle_cnt_out)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: posedges since reset release, link state, hold occupancy.
  int         cyc = 0;
  bit         active_m = 1'b0;
  bit [1:0]   hold_m = 2'b00;
  bit [1:0]   ready_m = 2'b00;
  int         idle_m = 0;
  bit         acc0, acc1;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         idx_q0[$];
  int         idx_q1[$];
  logic [7:0] sh0 = 8'h00;
  logic [7:0] sh1 = 8'h00;
  logic [7:0] e0, e1;
  int         wj;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Word j is loaded at posedge 8*(j+1); a byte accepted at posedge p lands in word p/8.
  always @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      cyc = 0;
      active_m = 1'b0;
      hold_m = 2'b00;
      ready_m = 2'b00;
      idle_m = 0;
      exp_q0.delete();
      exp_q1.delete();
      idx_q0.delete();
      idx_q1.delete();
    end else begin
      cyc++;
      acc0 = valid_in_c_0 && ready_m[0];
      acc1 = valid_in_c_1 && ready_m[1];
      if (cyc % 8 == 0) begin
        if (active_m) begin
          if (!hold_m[0] && idle_m < 255) idle_m++;
          hold_m = 2'b00;
        end else if (cyc == 8 * SYNC_WORDS) begin
          active_m = 1'b1;
        end
      end
      if (acc0) begin
        hold_m[0] = 1'b1;
        exp_q0.push_back(data_in_c_0);
        idx_q0.push_back(cyc / 8);
      end
      if (acc1) begin
        hold_m[1] = 1'b1;
        exp_q1.push_back(data_in_c_1);
        idx_q1.push_back(cyc / 8);
      end
      ready_m = active_m ? ~hold_m : 2'b00;
    end
  end

  always @(negedge clk_8f) begin
    if (reset) begin
      check("rst_data0", 8'(data_out_c_0), 8'd0);
      check("rst_data1", 8'(data_out_c_1), 8'd0);
      check("rst_ready", {6'd0, ready_out_c_1, ready_out_c_0}, 8'd0);
      check("rst_active", 8'(active_out), 8'd0);
    end else begin
      if (cyc < 8) begin
        check("pre_load_data0", 8'(data_out_c_0), 8'd0);
        check("pre_load_data1", 8'(data_out_c_1), 8'd0);
      end else begin
        sh0 = {sh0[6:0], data_out_c_0};
        sh1 = {sh1[6:0], data_out_c_1};
        if (cyc % 8 == 7) begin
          wj = cyc / 8 - 1;
          e0 = COMMA_WORD;
          e1 = COMMA_WORD;
          if (idx_q0.size() > 0 && idx_q0[0] == wj) begin
            e0 = exp_q0.pop_front();
            void'(idx_q0.pop_front());
          end
          if (idx_q1.size() > 0 && idx_q1[0] == wj) begin
            e1 = exp_q1.pop_front();
            void'(idx_q1.pop_front());
          end
          check("word_lane0", sh0, e0);
          check("word_lane1", sh1, e1);
        end
      end
      check("ready0", 8'(ready_out_c_0), 8'(ready_m[0]));
      check("ready1", 8'(ready_out_c_1), 8'(ready_m[1]));
      check("active", 8'(active_out), 8'(active_m));
`ifdef PHY_TX_STATUS_EN
      check("idle_cnt", idle_cnt_out, 8'(idle_m));
`endif
    end
  end

  // All driver tasks start and return on a negedge.
  task automatic wait_cyc(input int t);
    int guard = 0;
    while (cyc != t && guard < 5000) begin
      @(negedge clk_8f);
      guard++;
    end
    check("wait_cyc", 8'(cyc == t), 8'd1);
  endtask

  task automatic send(input int lane, input logic [7:0] b);
    int guard = 0;
    while (!ready_m[lane] && guard < 200) begin
      @(negedge clk_8f);
      guard++;
    end
    check("send_ready_timeout", 8'(ready_m[lane]), 8'd1);
    if (lane == 0) begin
      data_in_c_0 = b;
      valid_in_c_0 = 1'b1;
    end else begin
      data_in_c_1 = b;
      valid_in_c_1 = 1'b1;
    end
    @(posedge clk_8f);
    @(negedge clk_8f);
    valid_in_c_0 = 1'b0;
    valid_in_c_1 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b0, input logic [7:0] b1);
    int guard = 0;
    while (ready_m != 2'b11 && guard < 200) begin
      @(negedge clk_8f);
      guard++;
    end
    check("send2_ready_timeout", 8'(ready_m), 8'd3);
    data_in_c_0 = b0;
    data_in_c_1 = b1;
    valid_in_c_0 = 1'b1;
    valid_in_c_1 = 1'b1;
    @(posedge clk_8f);
    @(negedge clk_8f);
    valid_in_c_0 = 1'b0;
    valid_in_c_1 = 1'b0;
  endtask

  int b;
  int t;

  initial begin
    // Step 1: reset, sync burst, ACTIVE and ready rise on the 4th load edge.
    repeat (3) @(posedge clk_8f);
    @(negedge clk_8f);
    reset = 1'b0;
    wait_cyc(31);
    check("sync_active_low", 8'(active_out), 8'd0);
    check("sync_ready_low", {6'd0, ready_out_c_1, ready_out_c_0}, 8'd0);
    wait_cyc(32);
    check("active_rise", 8'(active_out), 8'd1);
    check("ready_rise", {6'd0, ready_out_c_1, ready_out_c_0}, 8'd3);

    // Step 2: one byte per lane, framed by COMMA idle words.
    send2(8'hA5, 8'h3C);
    t = cyc + 24;
    wait_cyc(t);

    // Step 3: back-to-back bytes on lane 0.
    send(0, 8'h01);
    send(0, 8'h02);
    send(0, 8'h03);
    t = cyc + 20;
    wait_cyc(t);

    // Step 4: valid presented just before a load edge with hold empty.
    t = (cyc / 8) * 8 + 15;
    wait_cyc(t);
    check("pre_boundary_ready1", 8'(ready_out_c_1), 8'd1);
    send(1, 8'h5A);
    t = cyc + 24;
    wait_cyc(t);

    // Step 5: reset while 0xFF is on the wire and 0x77 is held.
    send(0, 8'hFF);
    send(0, 8'h77);
    b = cyc - 1;
    wait_cyc(b + 4);
    #2;
    reset = 1'b1;
    #1;
    check("abort_data0", 8'(data_out_c_0), 8'd0);
    check("abort_data1", 8'(data_out_c_1), 8'd0);
    check("abort_ready", {6'd0, ready_out_c_1, ready_out_c_0}, 8'd0);
    check("abort_active", 8'(active_out), 8'd0);
    repeat (3) @(posedge clk_8f);
    @(negedge clk_8f);
    reset = 1'b0;
    wait_cyc(72);

    // Step 6: idle-word counter after a fresh reset with no data offered.
`ifdef PHY_TX_STATUS_EN
    check("idle_cnt_5", idle_cnt_out, 8'd5);
    wait_cyc(8 * SYNC_WORDS + 8 * 301);
    check("idle_cnt_sat", idle_cnt_out, 8'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
